// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input, MSB-first bit stream out.
// Optional SER_PARITY_EN appends an even-parity bit after each word's data bits.
module bit_serializer #(
  parameter int DATA_W = 8,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              word_done
);

  // state   | meaning
  // S_IDLE  | waiting for a word, din_ready high
  // S_SHIFT | a bit of the current word is on ser_out
  // S_GAP   | inter-word idle cycles, ser_out held low
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int BIT_CW = $clog2(DATA_W);
  localparam int GAP_CW = (GAP > 0) ? (($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1) : 1;

  localparam logic [BIT_CW-1:0] BIT_LOAD = BIT_CW'(DATA_W - 1);
  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]        r_state;
  logic [DATA_W-2:0] r_shift;
  logic [BIT_CW-1:0] r_bit_cnt;
  logic [GAP_CW-1:0] r_gap_cnt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_word_done;

  logic w_data_last;
  logic w_word_end;
  logic w_xfer;

`ifdef SER_PARITY_EN
  logic r_parity;
  logic r_par_phase;

  assign w_data_last = (r_state == S_SHIFT) && (r_bit_cnt == '0) && !r_par_phase;
  assign w_word_end  = (r_state == S_SHIFT) && r_par_phase;
`else
  assign w_data_last = (r_state == S_SHIFT) && (r_bit_cnt == '0);
  assign w_word_end  = w_data_last;
`endif

  // Ready only in IDLE or on the final bit of a word when streaming back-to-back.
  assign din_ready = (r_state == S_IDLE) || (w_word_end && (GAP == 0));
  assign w_xfer    = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_word_done <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity    <= 1'b0;
      r_par_phase <= 1'b0;
`endif
    end else begin
      r_word_done <= 1'b0;
      if (w_xfer) begin
        // A transfer can only happen in IDLE or on the word-end bit, so it always reloads.
        r_state     <= S_SHIFT;
        r_shift     <= din[DATA_W-2:0];
        r_bit_cnt   <= BIT_LOAD;
        r_ser_out   <= din[DATA_W-1];
        r_ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
        r_parity    <= ^din;
        r_par_phase <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
          end
          S_SHIFT: begin
            if (w_word_end) begin
              r_ser_out   <= 1'b0;
              r_ser_valid <= 1'b0;
              if (GAP > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= GAP_LOAD;
              end else begin
                r_state   <= S_IDLE;
              end
`ifdef SER_PARITY_EN
            end else if (w_data_last) begin
              r_ser_out   <= r_parity;
              r_par_phase <= 1'b1;
              r_word_done <= 1'b1;
`endif
            end else begin
              r_ser_out   <= r_shift[DATA_W-2];
              r_shift     <= r_shift << 1;
              r_bit_cnt   <= r_bit_cnt - 1'b1;
`ifndef SER_PARITY_EN
              r_word_done <= (r_bit_cnt == BIT_CW'(1));
`endif
            end
          end
          S_GAP: begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            if (r_gap_cnt == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign word_done = r_word_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one instance streaming back-to-back (GAP=0), one with GAP=2.
// Expected bit patterns are hand-derived from the test words; parity bit included when SER_PARITY_EN is set.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = 8 + PAR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din_a, din_b;
  logic valid_a, valid_b;
  logic ready_a, sout_a, sval_a, busy_a, done_a;
  logic ready_b, sout_b, sval_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.DATA_W(8), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .ser_out(sout_a), .ser_valid(sval_a), .busy(busy_a), .word_done(done_a)
  );

  bit_serializer #(.DATA_W(8), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .ser_out(sout_b), .ser_valid(sval_b), .busy(busy_b), .word_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return (i < 8) ? w[7-i] : ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream_a(input string tag, input logic [7:0] w, input int i);
    chk({tag, "_val"},   sval_a,  1);
    chk({tag, "_bit"},   sout_a,  exp_bit(w, i));
    chk({tag, "_done"},  done_a,  (i == W - 1));
    chk({tag, "_ready"}, ready_a, (i == W - 1));
    chk({tag, "_busy"},  busy_a,  1);
  endtask

  task automatic stream_b(input string tag, input logic [7:0] w, input int i);
    chk({tag, "_val"},   sval_b,  1);
    chk({tag, "_bit"},   sout_b,  exp_bit(w, i));
    chk({tag, "_done"},  done_b,  (i == W - 1));
    chk({tag, "_ready"}, ready_b, 0);
    chk({tag, "_busy"},  busy_b,  1);
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_val"},   sval_a,  0);
    chk({tag, "_bit"},   sout_a,  0);
    chk({tag, "_busy"},  busy_a,  0);
    chk({tag, "_ready"}, ready_a, 1);
    chk({tag, "_done"},  done_a,  0);
  endtask

  task automatic gap_b(input string tag);
    chk({tag, "_val"},   sval_b,  0);
    chk({tag, "_bit"},   sout_b,  0);
    chk({tag, "_busy"},  busy_b,  1);
    chk({tag, "_ready"}, ready_b, 0);
  endtask

  initial begin
    din_a = '0; valid_a = 1'b0;
    din_b = '0; valid_b = 1'b0;

    // reset state
    #12;
    idle_a("rst_a");
    chk("rst_b_ready", ready_b, 1);
    chk("rst_b_busy",  busy_b,  0);

    // single word 8'hB4
    @(negedge clk);
    rst = 1'b0;
    din_a = 8'hB4; valid_a = 1'b1;
    #1;
    chk("b4_ready_idle", ready_a, 1);
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < W; i++) begin
      stream_a("b4", 8'hB4, i);
      tick();
    end
    idle_a("b4_after");

    // back-to-back B0 then 2C, second word held while first shifts
    din_a = 8'hB0; valid_a = 1'b1;
    tick();
    din_a = 8'h2C;
    for (int i = 0; i < W; i++) begin
      stream_a("b0", 8'hB0, i);
      tick();
    end
    valid_a = 1'b0;
    for (int i = 0; i < W; i++) begin
      stream_a("2c", 8'h2C, i);
      tick();
    end
    idle_a("b2b_after");

    // reset mid-word, then a clean word
    din_a = 8'hFF; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stream_a("ff", 8'hFF, i);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    idle_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    din_a = 8'h0B; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < W; i++) begin
      stream_a("0b", 8'h0B, i);
      tick();
    end
    idle_a("0b_after");

    // GAP=2 instance: two words with gap and one IDLE cycle between
    din_b = 8'hB4; valid_b = 1'b1;
    tick();
    din_b = 8'h2C;
    for (int i = 0; i < W; i++) begin
      stream_b("g_b4", 8'hB4, i);
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      gap_b("g_gap1");
      tick();
    end
    chk("g_idle_val",   sval_b,  0);
    chk("g_idle_busy",  busy_b,  0);
    chk("g_idle_ready", ready_b, 1);
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < W; i++) begin
      stream_b("g_2c", 8'h2C, i);
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      gap_b("g_gap2");
      tick();
    end
    chk("g_end_busy",  busy_b,  0);
    chk("g_end_ready", ready_b, 1);
    chk("g_end_val",   sval_b,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
